// File: rtl/keccak_round_ctrl.sv
// keccak_round_ctrl: owns the 5x5x64 Keccak state and walks an external
// combinational step unit through theta, rho, pi, chi, iota once per cycle
// for NUM_ROUNDS rounds, with valid/ready handshakes on both sides.

// One 64-bit lane of the state register.
module keccak_lane_reg #(
  parameter int LANE_SIZE = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load_i,
  input  logic                 step_i,
  input  logic [LANE_SIZE-1:0] load_d_i,
  input  logic [LANE_SIZE-1:0] step_d_i,
  output logic [LANE_SIZE-1:0] q_o
);

  // Load takes priority; the controller never asserts load and step together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      q_o <= '0;
    else if (load_i) q_o <= load_d_i;
    else if (step_i) q_o <= step_d_i;
  end

endmodule

module keccak_round_ctrl #(
  parameter  int NUM_ROUNDS       = 24,
  localparam int ROW_SIZE         = 5,
  localparam int COL_SIZE         = 5,
  localparam int LANE_SIZE        = 64,
  localparam int ROUND_INDEX_SIZE = 5,
  localparam int STEP_SEL_WIDTH   = 3,
  localparam int STATE_W          = ROW_SIZE * COL_SIZE * LANE_SIZE
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid_i,
  output logic                        in_ready_o,
  input  logic [STATE_W-1:0]          state_i,
  output logic                        out_valid_o,
  input  logic                        out_ready_i,
  output logic [STATE_W-1:0]          state_o,
  output logic [STEP_SEL_WIDTH-1:0]   step_sel_o,
  output logic [ROUND_INDEX_SIZE-1:0] round_index_o,
  output logic [STATE_W-1:0]          step_state_o,
  input  logic [STATE_W-1:0]          step_result_i,
  output logic                        busy_o
);

  localparam int NUM_LANES = ROW_SIZE * COL_SIZE;

  localparam logic [ROUND_INDEX_SIZE-1:0] LAST_ROUND = ROUND_INDEX_SIZE'(NUM_ROUNDS - 1);

  // Step codes seen by the step unit; 5 and 6 are never produced.
  localparam logic [STEP_SEL_WIDTH-1:0] THETA_STEP = 3'd0;
  localparam logic [STEP_SEL_WIDTH-1:0] RHO_STEP   = 3'd1;
  localparam logic [STEP_SEL_WIDTH-1:0] PI_STEP    = 3'd2;
  localparam logic [STEP_SEL_WIDTH-1:0] CHI_STEP   = 3'd3;
  localparam logic [STEP_SEL_WIDTH-1:0] IOTA_STEP  = 3'd4;
  localparam logic [STEP_SEL_WIDTH-1:0] IDLE_STEP  = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } fsm_e;

  fsm_e                          fsm_q, fsm_d;
  logic [STEP_SEL_WIDTH-1:0]     step_q, step_d;
  logic [ROUND_INDEX_SIZE-1:0]   round_q, round_d;
  logic                          load, capture, step_ok;
  logic [NUM_LANES-1:0][LANE_SIZE-1:0] state_q;

  // Control registers: FSM, step and round counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q   <= S_IDLE;
      step_q  <= THETA_STEP;
      round_q <= '0;
    end else begin
      fsm_q   <= fsm_d;
      step_q  <= step_d;
      round_q <= round_d;
    end
  end

  // Next-state logic; any out-of-range FSM/step/round code falls back to IDLE.
  always_comb begin
    fsm_d   = fsm_q;
    step_d  = step_q;
    round_d = round_q;
    load    = 1'b0;
    capture = 1'b0;
    step_ok = (step_q <= IOTA_STEP) && (round_q <= LAST_ROUND);
    case (fsm_q)
      S_IDLE: begin
        if (in_valid_i) begin
          load    = 1'b1;
          fsm_d   = S_RUN;
          step_d  = THETA_STEP;
          round_d = '0;
        end
      end
      S_RUN: begin
        if (!step_ok) begin
          fsm_d   = S_IDLE;
          step_d  = THETA_STEP;
          round_d = '0;
        end else begin
          capture = 1'b1;
          if (step_q == IOTA_STEP) begin
            step_d = THETA_STEP;
            if (round_q == LAST_ROUND) begin
              fsm_d   = S_DONE;
              round_d = '0;
            end else begin
              round_d = round_q + ROUND_INDEX_SIZE'(1);
            end
          end else begin
            step_d = step_q + STEP_SEL_WIDTH'(1);
          end
        end
      end
      S_DONE: begin
        if (out_ready_i) fsm_d = S_IDLE;
      end
      default: begin
        fsm_d   = S_IDLE;
        step_d  = THETA_STEP;
        round_d = '0;
      end
    endcase
  end

  // State register, one lane instance per (row, col); lane l = row*COL_SIZE + col.
  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    keccak_lane_reg #(.LANE_SIZE(LANE_SIZE)) u_lane (
      .clk      (clk),
      .rst_n    (rst_n),
      .load_i   (load),
      .step_i   (capture),
      .load_d_i (state_i[l*LANE_SIZE +: LANE_SIZE]),
      .step_d_i (step_result_i[l*LANE_SIZE +: LANE_SIZE]),
      .q_o      (state_q[l])
    );
  end

  // Output decode from registered state only; nothing depends on out_ready_i.
  always_comb begin
    in_ready_o    = (fsm_q == S_IDLE);
    busy_o        = (fsm_q == S_RUN);
    out_valid_o   = (fsm_q == S_DONE);
    round_index_o = round_q;
    step_sel_o    = IDLE_STEP;
    if (fsm_q == S_RUN && step_q <= IOTA_STEP) step_sel_o = step_q;
  end

  assign state_o      = state_q;
  assign step_state_o = state_q;

endmodule

// File: doc/keccak_round_ctrl.md
Name: keccak_round_ctrl

Overview:
- Sequencer that owns the 5x5x64 Keccak state register and drives keccak_step_unit one step mapping per cycle.
- Runs the order theta, rho, pi, chi, iota for NUM_ROUNDS rounds, which produces Keccak-f[1600].
- Sits between the absorb/squeeze logic (valid/ready on both sides) and the combinational step unit.

Parameters:
- NUM_ROUNDS, 24, rounds per permutation. Legal range 1..24. The round index must fit ROUND_INDEX_SIZE.

Ports:
- clk  in  1  system clock, all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid_i  in  1  a new state is offered on state_i.
- in_ready_o  out  1  controller can accept a state (high only in IDLE).
- state_i  in  ROW_SIZE*COL_SIZE*LANE_SIZE (1600)  input state, packed [ROW][COL][LANE].
- out_valid_o  out  1  permuted state is valid on state_o.
- out_ready_i  in  1  downstream accepts state_o.
- state_o  out  1600  current state register, always driven.
- step_sel_o  out  STEP_SEL_WIDTH  step select to keccak_step_unit.step_sel_i.
- round_index_o  out  ROUND_INDEX_SIZE  current round to keccak_step_unit.round_index_i.
- step_state_o  out  1600  state register value, to keccak_step_unit.state_array_i.
- step_result_i  in  1600  keccak_step_unit.state_array_o.
- busy_o  out  1  high in RUN.

Behaviour:
- Reset (async, rst_n=0):
  - FSM goes to IDLE; state register, step counter and round counter clear to 0.
  - Outputs: out_valid_o=0, busy_o=0, in_ready_o=1, step_sel_o=IDLE_STEP, round_index_o=0, state_o=0.
- FSM states: IDLE, RUN, DONE. Encoding is free.
- IDLE:
  - in_ready_o=1; step_sel_o=IDLE_STEP.
  - On in_valid_i=1: state_reg<=state_i, step<=THETA_STEP, round<=0, go to RUN.
- RUN:
  - step_sel_o = current step; round_index_o = round.
  - Every cycle: state_reg<=step_result_i.
  - Step advances THETA->RHO->PI->CHI->IOTA->THETA. round increments on the IOTA->THETA transition.
  - On IOTA with round==NUM_ROUNDS-1: capture the result, go to DONE, round<=0.
  - in_ready_o=0; in_valid_i is ignored.
- DONE:
  - out_valid_o=1; state_o holds the final state, stable until accepted; step_sel_o=IDLE_STEP.
  - On out_ready_i=1: go to IDLE. A new input is accepted no earlier than the following cycle, because in_ready_o=0 in DONE.
- Latency:
  - The accept edge is cycle 0. RUN occupies 5*NUM_ROUNDS cycles (120 at default).
  - out_valid_o rises the cycle after the last IOTA capture, i.e. 121 cycles after accept.
  - RUN cycle k (0-based) uses step index k mod 5 and round k div 5.
- Counters:
  - The step counter is 3 bits, using only the five legal codes.
  - The round counter never exceeds NUM_ROUNDS-1.
  - An illegal FSM or step code forces a return to IDLE with step_sel_o=IDLE_STEP.
- out_valid_o stays high indefinitely while out_ready_i=0; no data change is allowed.
- Reset mid-RUN or mid-DONE aborts immediately; the partial state is discarded (cleared to 0).
- Output handshake: out_valid_o must not depend combinationally on out_ready_i.
- All outputs are registered or decoded from registered FSM/counter state only.

Test Plan:
- Zero permutation: reset, then send state_i=all zeros with out_ready_i=1.
  - Require in_ready_o=0 for 121 cycles.
  - Require out_valid_o at cycle 121 and lane[0][0]=0xF1258F7940E1DDE7, matching the reference Keccak-f[1600] model for all 25 lanes.
- Sequencing check: monitor step_sel_o/round_index_o during RUN.
  - Require exactly 24 repetitions of THETA,RHO,PI,CHI,IOTA.
  - Require round_index_o to step 0..23, changing only after IOTA, with no IDLE_STEP inside RUN.
- Backpressure: hold out_ready_i=0 for 50 cycles after done.
  - Require out_valid_o=1 and state_o constant throughout, in_ready_o=0, and step_sel_o=IDLE_STEP.
  - Release out_ready_i: IDLE next cycle.
- Ignored input: pulse in_valid_i with a random state at RUN cycle 60.
  - Require no capture and a result identical to the undisturbed run.
- Reset mid-operation: assert rst_n=0 at RUN cycle 37, asynchronously, between clock edges.
  - Require immediate out_valid_o=0, busy_o=0, state_o=0 and in_ready_o=1.
  - A new zero-state run must then yield 0xF1258F7940E1DDE7.
- Back-to-back: two random states with out_ready_i tied high.
  - Both results must match the model.
  - The second accept occurs no earlier than 2 cycles after the first out_valid_o.
  - Run a NUM_ROUNDS=1 variant: 5 RUN cycles.
